leaf_user_in_fifo: RTL and testbench

//  Elastic buffer between one leaf_interface user-side output port (dout_leaf_interface2user_N,
//  vld_interface2user_N, ack_user2interface_N) and one user-kernel stream input (tdata/tvalid/tready).
//  It decouples the user kernel's back-pressure from the interface's vld/ack handshake.
//  It also keeps a per-port accepted-word count for bring-up debug.
//  One instance is placed per input port inside the leaf shell, in the clk_user domain.

---
 rtl/leaf_user_in_fifo.sv | 103 ++++++++++
 tb/tb_leaf_user_in_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_user_in_fifo.sv
// leaf_user_in_fifo
// Elastic first-word-fall-through buffer between a leaf_interface user-side
// output port (vld/ack handshake) and a user-kernel stream input
// (tdata/tvalid/tready). It also keeps an accepted-word counter for bring-up.
// Full and empty are told apart by the occupancy counter, not by pointer compare.
module leaf_user_in_fifo #(
   parameter int PAYLOAD_BITS = 32,
   parameter int DEPTH_BITS   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                    clk_user,
   input  logic                    reset_n,
   input  logic [PAYLOAD_BITS-1:0] din_interface,
   input  logic                    vld_interface,
   output logic                    ack_interface,
   output logic [PAYLOAD_BITS-1:0] dout_tdata,
   output logic                    dout_tvalid,
   input  logic                    dout_tready,
   input  logic                    flush,
   input  logic                    clear_cnt,
   output logic [DEPTH_BITS:0]     occupancy,
   output logic                    almost_full,
   output logic [31:0]             word_cnt
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0]   OCC_FULL = (DEPTH_BITS+1)'(DEPTH);
   localparam logic [DEPTH_BITS:0]   OCC_AF   = (DEPTH_BITS+1)'(AFULL_THRESH);
   localparam logic [DEPTH_BITS:0]   OCC_ONE  = (DEPTH_BITS+1)'(1);
   localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];

   logic [DEPTH_BITS-1:0] wr_ptr_reg, wr_ptr_next;
   logic [DEPTH_BITS-1:0] rd_ptr_reg, rd_ptr_next;
   logic [DEPTH_BITS:0]   occ_reg, occ_next;
   logic                  af_reg;
   logic                  ready_reg;
   logic [31:0]           cnt_reg, cnt_next;
   logic                  full;
   logic                  push;
   logic                  pop;

   // ready_reg holds ack low through reset and the edge on which it is released,
   // so the first acknowledge comes at the first clock edge after release.
   assign full          = (occ_reg == OCC_FULL);
   assign ack_interface = ready_reg & ~flush & ~full;
   assign push          = vld_interface & ack_interface;
   assign pop           = dout_tvalid & dout_tready;

   // Head of storage is shown directly; masked to zero while empty so stale
   // memory contents never leak out (and the reset value is zero).
   assign dout_tvalid = (occ_reg != '0);
   assign dout_tdata  = dout_tvalid ? mem[rd_ptr_reg] : '0;
   assign occupancy   = occ_reg;
   assign almost_full = af_reg;
   assign word_cnt    = cnt_reg;

   // Next-state pointers, occupancy and counter; flush wins over push/pop.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      occ_next    = occ_reg;
      cnt_next    = cnt_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         occ_next    = '0;
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
         if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
         if (push && !pop)      occ_next = occ_reg + OCC_ONE;
         else if (pop && !push) occ_next = occ_reg - OCC_ONE;
      end
      if (clear_cnt)  cnt_next = '0;
      else if (push)  cnt_next = cnt_reg + 32'd1;
   end

   // Control state; everything resets asynchronously so data is dropped at once.
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
         af_reg     <= 1'b0;
         ready_reg  <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         occ_reg    <= occ_next;
         af_reg     <= (occ_next >= OCC_AF);
         ready_reg  <= 1'b1;
         cnt_reg    <= cnt_next;
      end
   end

   // Storage array; no reset needed because reads are masked by occupancy.
   always_ff @(posedge clk_user) begin
      if (push) mem[wr_ptr_reg] <= din_interface;
   end

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Bench for leaf_user_in_fifo: vector table for fill/full/release, a reference
// model with a data scoreboard for streaming, random traffic, flush and reset.
module tb_leaf_user_in_fifo;

   logic        clk_user = 1'b0;
   logic        reset_n  = 1'b0;
   logic [31:0] din_interface = '0;
   logic        vld_interface = 1'b0;
   logic        ack_interface;
   logic [31:0] dout_tdata;
   logic        dout_tvalid;
   logic        dout_tready = 1'b0;
   logic        flush = 1'b0;
   logic        clear_cnt = 1'b0;
   logic [3:0]  occupancy;
   logic        almost_full;
   logic [31:0] word_cnt;

   always #5 clk_user = ~clk_user;

   leaf_user_in_fifo #(.PAYLOAD_BITS(32), .DEPTH_BITS(3), .AFULL_THRESH(6)) dut (
      .clk_user     (clk_user),
      .reset_n      (reset_n),
      .din_interface(din_interface),
      .vld_interface(vld_interface),
      .ack_interface(ack_interface),
      .dout_tdata   (dout_tdata),
      .dout_tvalid  (dout_tvalid),
      .dout_tready  (dout_tready),
      .flush        (flush),
      .clear_cnt    (clear_cnt),
      .occupancy    (occupancy),
      .almost_full  (almost_full),
      .word_cnt     (word_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   logic [31:0] q[$];
   int          m_occ   = 0;
   int          max_occ = 0;
   logic [31:0] m_cnt   = '0;
   logic        m_ready = 1'b0;
   int          n_pushes = 0;
   int          n_pops   = 0;
   logic        exp_ack;
   logic        cur_v, cur_r, cur_f, cur_c;
   logic [31:0] cur_d;

   typedef struct {
      logic        vld;
      logic [31:0] din;
      logic        rdy;
      int          e_occ;
      logic        e_tvalid;
      logic [31:0] e_tdata;
      logic        e_ack;
      logic        e_af;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and compare against the model.
   task automatic drive(input logic v, input logic [31:0] d, input logic r,
                        input logic f, input logic c);
      @(negedge clk_user);
      vld_interface = v; din_interface = d; dout_tready = r; flush = f; clear_cnt = c;
      cur_v = v; cur_d = d; cur_r = r; cur_f = f; cur_c = c;
      #1;
      exp_ack = m_ready && !f && (m_occ < 8);
      chk("ack", 64'(ack_interface), 64'(exp_ack));
      chk("tvalid", 64'(dout_tvalid), 64'(m_occ != 0));
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("almost_full", 64'(almost_full), 64'(m_occ >= 6));
      chk("word_cnt", 64'(word_cnt), 64'(m_cnt));
   endtask

   // Advance the model by the handshakes of the current cycle, then take the edge.
   task automatic commit();
      logic        do_push, do_pop;
      logic [31:0] exp_d;
      do_push = cur_v && exp_ack;
      do_pop  = (m_occ != 0) && cur_r;
      if (cur_f) begin
         q.delete();
         m_occ = 0;
      end else begin
         if (do_pop) begin
            exp_d = q.pop_front();
            chk("pop_data", 64'(dout_tdata), 64'(exp_d));
            n_pops++;
         end
         if (do_push) begin
            q.push_back(cur_d);
            n_pushes++;
         end
         m_occ = m_occ + int'(do_push) - int'(do_pop);
      end
      if (m_occ > max_occ) max_occ = m_occ;
      m_cnt = cur_c ? 32'd0 : m_cnt + 32'(do_push);
      @(posedge clk_user);
      m_ready = 1'b1;
   endtask

   task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                        input logic f, input logic c);
      drive(v, d, r, f, c);
      commit();
   endtask

   // Assert reset for one full clock, check outputs immediately, release.
   task automatic do_reset();
      @(negedge clk_user);
      reset_n = 1'b0;
      vld_interface = 1'b0; dout_tready = 1'b0; flush = 1'b0; clear_cnt = 1'b0;
      #1;
      chk("rst_tvalid", 64'(dout_tvalid), 64'd0);
      chk("rst_tdata", 64'(dout_tdata), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_almost_full", 64'(almost_full), 64'd0);
      chk("rst_word_cnt", 64'(word_cnt), 64'd0);
      chk("rst_ack", 64'(ack_interface), 64'd0);
      q.delete(); m_occ = 0; m_cnt = '0; m_ready = 1'b0;
      @(negedge clk_user);
      reset_n = 1'b1;
      #1;
      chk("release_ack_low", 64'(ack_interface), 64'd0);
      @(posedge clk_user);
      m_ready = 1'b1;
      $display("reset applied and released");
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && m_occ != 0; k++) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("drained", 64'(m_occ), 64'd0);
   endtask

   initial begin
      int start_push;
      int pops0;

      // fill 0x11..0x18 with tready low, attempt a 9th push, release one word
      tbl[0]  = '{1'b1, 32'h11, 1'b0, 0, 1'b0, 32'h00, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 32'h12, 1'b0, 1, 1'b1, 32'h11, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 32'h13, 1'b0, 2, 1'b1, 32'h11, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 32'h14, 1'b0, 3, 1'b1, 32'h11, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 32'h15, 1'b0, 4, 1'b1, 32'h11, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 32'h16, 1'b0, 5, 1'b1, 32'h11, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 32'h17, 1'b0, 6, 1'b1, 32'h11, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 32'h18, 1'b0, 7, 1'b1, 32'h11, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 32'h99, 1'b0, 8, 1'b1, 32'h11, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 32'h00, 1'b1, 8, 1'b1, 32'h11, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 32'h00, 1'b0, 7, 1'b1, 32'h12, 1'b1, 1'b1};

      do_reset();

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].vld, tbl[i].din, tbl[i].rdy, 1'b0, 1'b0);
         chk("vec_occupancy", 64'(occupancy), 64'(tbl[i].e_occ));
         chk("vec_tvalid", 64'(dout_tvalid), 64'(tbl[i].e_tvalid));
         if (tbl[i].e_tvalid) chk("vec_tdata", 64'(dout_tdata), 64'(tbl[i].e_tdata));
         chk("vec_ack", 64'(ack_interface), 64'(tbl[i].e_ack));
         chk("vec_almost_full", 64'(almost_full), 64'(tbl[i].e_af));
         $display("vec %0d: vld=%0b din=%08h rdy=%0b occ=%0d tvalid=%0b tdata=%08h ack=%0b af=%0b",
                  i, tbl[i].vld, tbl[i].din, tbl[i].rdy, occupancy, dout_tvalid,
                  dout_tdata, ack_interface, almost_full);
         commit();
      end
      drain();

      // continuous streaming, 100 words
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      pops0 = n_pops;
      for (int i = 0; i < 100; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_pops", 64'(n_pops - pops0), 64'd99);
      drain();
      #1;
      chk("stream_word_cnt", 64'(word_cnt), 64'd100);
      $display("stream: 100 words, pops in window %0d", n_pops - pops0);

      // random traffic, 10k words
      start_push = n_pushes;
      for (int k = 0; k < 60000 && (n_pushes - start_push) < 10000; k++)
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      chk("random_words", 64'((n_pushes - start_push) >= 10000), 64'd1);
      drain();
      chk("max_occupancy", 64'(max_occ <= 8), 64'd1);
      $display("random: %0d words pushed, max occupancy %0d", n_pushes - start_push, max_occ);

      // flush with 5 stored words and tready high, then clear together with push
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      chk("flush_tvalid", 64'(dout_tvalid), 64'd0);
      chk("flush_word_cnt", 64'(word_cnt), 64'd5);
      commit();
      cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("clear_push_word_cnt", 64'(word_cnt), 64'd0);
      chk("clear_push_occupancy", 64'(occupancy), 64'd1);
      commit();
      drain();
      $display("flush and clear sequence done");

      // reset with 4 words stored, then 0xAB must be the first word out
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0, 1'b0);
      do_reset();
      cycle(1'b1, 32'hAB, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("post_reset_first", 64'(dout_tdata), 64'hAB);
      commit();
      drain();
      $display("reset mid-transfer sequence done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends on its own.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
